if_stage: RTL and testbench

//  Instruction-fetch stage of the RV64 core; directly upstream of the decode stage.

---
 rtl/if_stage_pkg.sv | 19 +
 rtl/if_pc_gen.sv | 36 +++
 rtl/if_stage.sv | 162 ++++++++++++++++
 tb/tb_if_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_pkg
// Description : Shared constants and state encoding for the instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package if_stage_pkg;

  localparam logic [63:0] C_RESET_PC  = 64'h0000_0000_8000_0000;
  localparam logic [31:0] C_NOP_INST  = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_REQ  = 2'd0,
    IF_WAIT = 2'd1,
    IF_HOLD = 2'd2
  } if_state_t;

endpackage
`default_nettype wire

// File: rtl/if_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : if_pc_gen
// Description : Fetch PC register with +4 sequential update and redirect mux.
// Revision    : 1.0 - initial release
// ============================================================================
module if_pc_gen #(
  parameter int unsigned     PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            advance,
  input  logic [PC_W-1:0] fetch_pc,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] r_pc;

  // Redirect wins over the sequential step; the add wraps modulo 2^PC_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc;
    end else if (advance) begin
      r_pc <= fetch_pc + PC_W'(4);
    end
  end

  assign pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction fetch stage, one outstanding imem request, valid/ready
//               output to decode. Optional misaligned-fetch fault: IF_MISALIGN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned     PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(C_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_inst,
  output logic [PC_W-1:0] id_pc
`ifdef IF_MISALIGN_EN
  ,
  output logic            id_fault
`endif
);

  if_state_t       r_state,    w_state_nxt;
  logic            r_kill,     w_kill_nxt;
  logic            r_id_valid, w_id_valid_nxt;
  logic [31:0]     r_id_inst,  w_id_inst_nxt;
  logic [PC_W-1:0] r_id_pc,    w_id_pc_nxt;
  logic [PC_W-1:0] r_fetch_pc, w_fetch_pc_nxt;
  logic            w_advance;
  logic            w_issue;
  logic            w_misalign;
  logic [PC_W-1:0] w_pc;
`ifdef IF_MISALIGN_EN
  logic            r_fault,    w_fault_nxt;
`endif

  if_pc_gen #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .advance        (w_advance),
    .fetch_pc       (r_fetch_pc),
    .pc             (w_pc)
  );

`ifdef IF_MISALIGN_EN
  assign w_misalign = (w_pc[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_issue   = (r_state == IF_REQ) && !w_misalign;
  assign imem_req  = w_issue && !rst;
  assign imem_addr = w_pc;

  always_comb begin
    w_state_nxt    = r_state;
    w_kill_nxt     = r_kill;
    w_id_valid_nxt = r_id_valid;
    w_id_inst_nxt  = r_id_inst;
    w_id_pc_nxt    = r_id_pc;
    w_fetch_pc_nxt = r_fetch_pc;
    w_advance      = 1'b0;
`ifdef IF_MISALIGN_EN
    w_fault_nxt    = r_fault;
`endif
    case (r_state)
      IF_REQ: begin
        // A grant in a redirect cycle was for the old address, so it is killed.
        if (w_issue && imem_gnt) begin
          w_fetch_pc_nxt = w_pc;
          w_kill_nxt     = redirect_valid;
          w_state_nxt    = IF_WAIT;
        end
`ifdef IF_MISALIGN_EN
        else if (w_misalign && !redirect_valid) begin
          w_id_valid_nxt = 1'b1;
          w_id_inst_nxt  = C_NOP_INST;
          w_id_pc_nxt    = w_pc;
          w_fault_nxt    = 1'b1;
          w_state_nxt    = IF_HOLD;
        end
`endif
      end
      IF_WAIT: begin
        if (imem_rvalid) begin
          if (r_kill || redirect_valid) begin
            w_kill_nxt  = 1'b0;
            w_state_nxt = IF_REQ;
          end else begin
            w_id_valid_nxt = 1'b1;
            w_id_inst_nxt  = imem_rdata;
            w_id_pc_nxt    = r_fetch_pc;
            w_advance      = 1'b1;
            w_state_nxt    = IF_HOLD;
          end
        end else if (redirect_valid) begin
          w_kill_nxt = 1'b1;
        end
      end
      IF_HOLD: begin
        if (id_ready || redirect_valid) begin
          w_id_valid_nxt = 1'b0;
`ifdef IF_MISALIGN_EN
          w_fault_nxt    = 1'b0;
`endif
          w_state_nxt    = IF_REQ;
        end
      end
      default: begin
        w_state_nxt = IF_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IF_REQ;
      r_kill     <= 1'b0;
      r_id_valid <= 1'b0;
      r_id_inst  <= C_NOP_INST;
      r_id_pc    <= '0;
      r_fetch_pc <= '0;
`ifdef IF_MISALIGN_EN
      r_fault    <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_kill     <= w_kill_nxt;
      r_id_valid <= w_id_valid_nxt;
      r_id_inst  <= w_id_inst_nxt;
      r_id_pc    <= w_id_pc_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
`ifdef IF_MISALIGN_EN
      r_fault    <= w_fault_nxt;
`endif
    end
  end

  assign id_valid = r_id_valid;
  assign id_inst  = r_id_inst;
  assign id_pc    = r_id_pc;
`ifdef IF_MISALIGN_EN
  assign id_fault = r_fault;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Directed and randomized self-checking bench for if_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

  localparam logic [63:0] C_RST_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [63:0] id_pc;
`ifdef IF_MISALIGN_EN
  logic        id_fault;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  if_stage #(
    .PC_W     (64),
    .RESET_PC (C_RST_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc)
`ifdef IF_MISALIGN_EN
    ,
    .id_fault       (id_fault)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory image: any address maps to a distinct, address-derived word.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A3C_0F13 ^ {a[9:2], 24'h0};
  endfunction

  // Reference model state (transaction level)
  logic [63:0] next_pc, out_addr, p_addr, p_inst_pc, rpc;
  logic [31:0] p_inst;
  logic        outst, p_redir, p_done, p_hold, p_valid, p_stall, redir, rdy, gnt;
  logic        s_req, s_v;
  logic [63:0] s_addr, s_pc;
  logic [31:0] s_inst;
  int          lat;

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;
    tick(); tick();
    check("rst_req",      64'(imem_req), 64'd0);
    check("rst_valid",    64'(id_valid), 64'd0);
    check("rst_inst",     64'(id_inst),  64'h13);
    check("rst_pc",       id_pc,         64'd0);

    // First fetch after reset, immediate grant, data one cycle later
    rst = 1'b0; #1;
    check("t1_req",  64'(imem_req), 64'd1);
    check("t1_addr", imem_addr, C_RST_PC);
    imem_gnt = 1'b1; tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093; id_ready = 1'b1; tick();
    imem_rvalid = 1'b0;
    check("t1_valid", 64'(id_valid), 64'd1);
    check("t1_inst",  64'(id_inst),  64'h0050_0093);
    check("t1_pc",    id_pc,         C_RST_PC);
    tick();
    check("t1_next_addr", imem_addr, C_RST_PC + 64'd4);

    // Decode stalls for five cycles
    id_ready = 1'b0; imem_gnt = 1'b1; tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_0B13; tick();
    imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t2_valid", 64'(id_valid), 64'd1);
      check("t2_inst",  64'(id_inst),  64'hCAFE_0B13);
      check("t2_pc",    id_pc,         C_RST_PC + 64'd4);
      check("t2_req",   64'(imem_req), 64'd0);
      tick();
    end
    id_ready = 1'b1; tick();
    id_ready = 1'b0;
    check("t2_next_addr", imem_addr, C_RST_PC + 64'd8);

    // Redirect while waiting, stale data arrives later
    imem_gnt = 1'b1; tick();
    imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_1000; tick();
    redirect_valid = 1'b0; tick();
    check("t3_valid_a", 64'(id_valid), 64'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111; tick();
    imem_rvalid = 1'b0;
    check("t3_valid_b", 64'(id_valid), 64'd0);
    check("t3_req",     64'(imem_req), 64'd1);
    check("t3_addr",    imem_addr,     64'h8000_1000);

    // PC wraps past the top of the address space
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; tick();
    redirect_valid = 1'b0;
    check("t5_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    imem_gnt = 1'b1; tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013; id_ready = 1'b1; tick();
    imem_rvalid = 1'b0;
    check("t5_pc", id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    id_ready = 1'b0;
    check("t5_wrap_addr", imem_addr, 64'd0);

`ifdef IF_MISALIGN_EN
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0002; tick();
    redirect_valid = 1'b0;
    check("t6_req", 64'(imem_req), 64'd0);
    tick();
    check("t6_valid", 64'(id_valid), 64'd1);
    check("t6_fault", 64'(id_fault), 64'd1);
    check("t6_inst",  64'(id_inst),  64'h13);
    check("t6_pc",    id_pc,         64'h8000_0002);
    redirect_valid = 1'b1; redirect_pc = C_RST_PC; tick();
    redirect_valid = 1'b0;
    check("t6_fault_clr", 64'(id_fault), 64'd0);
    check("t6_valid_clr", 64'(id_valid), 64'd0);
`endif

    // Randomized run against the transaction-level model
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    next_pc = C_RST_PC; outst = 1'b0; lat = 0; out_addr = '0;
    p_redir = 1'b0; p_done = 1'b0; p_hold = 1'b0; p_valid = 1'b0; p_stall = 1'b0;
    p_addr = '0; p_inst = '0; p_inst_pc = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      s_req = imem_req; s_addr = imem_addr; s_v = id_valid; s_inst = id_inst; s_pc = id_pc;
      if (p_redir) check("flush_after_redirect", 64'(s_v), 64'd0);
      if (p_done)  check("drop_after_handshake", 64'(s_v), 64'd0);
      if (p_hold) begin
        check("hold_valid", 64'(s_v),    64'd1);
        check("hold_inst",  64'(s_inst), 64'(p_inst));
        check("hold_pc",    s_pc,        p_inst_pc);
      end
      if (s_v && !p_valid) begin
        check("deliver_pc",   s_pc,        next_pc);
        check("deliver_inst", 64'(s_inst), 64'(mem_word(next_pc)));
      end
      if (outst) check("single_outstanding", 64'(s_req), 64'd0);
      if (p_stall) begin
        check("req_held",  64'(s_req), 64'd1);
        check("addr_held", s_addr,      p_addr);
      end

      redir = ($urandom_range(0, 99) < 6);
      if ($urandom_range(0, 7) == 0)
        rpc = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 1) * 4);
      else
        rpc = C_RST_PC + 64'($urandom_range(0, 1023) * 4);
      rdy = ($urandom_range(0, 9) < 6);
      gnt = s_req && ($urandom_range(0, 1) == 1);

      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (outst) begin
        if (lat == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(out_addr);
          outst       = 1'b0;
        end else begin
          lat--;
        end
      end
      if (gnt) begin
        if (!redir) check("fetch_addr", s_addr, next_pc);
        outst    = 1'b1;
        out_addr = s_addr;
        lat      = $urandom_range(0, 2);
      end

      imem_gnt = gnt; id_ready = rdy; redirect_valid = redir; redirect_pc = rpc;

      if (redir)          next_pc = rpc;
      else if (s_v && rdy) next_pc = next_pc + 64'd4;
      p_redir   = redir;
      p_done    = s_v && (rdy || redir);
      p_hold    = s_v && !rdy && !redir;
      p_valid   = s_v;
      p_stall   = s_req && !gnt && !redir;
      p_addr    = s_addr;
      p_inst    = s_inst;
      p_inst_pc = s_pc;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
